// File: rtl/mem_bank_load_sequencer_if.sv
// Bus-beat handshake and address-generator controls between the job sequencer and the
// bank side. Signal suffixes are named from the sequencer's point of view.
interface mem_bank_load_sequencer_if;
    logic bus_valid_i;
    logic bus_ready_o;
    logic gen_start_o;
    logic bank_a_valid_o;
    logic bank_b_valid_o;
    logic gen_clear_o;

    modport master (
        output bus_valid_i,
        input  bus_ready_o,
        input  gen_start_o,
        input  bank_a_valid_o,
        input  bank_b_valid_o,
        input  gen_clear_o
    );

    modport slave (
        input  bus_valid_i,
        output bus_ready_o,
        output gen_start_o,
        output bank_a_valid_o,
        output bank_b_valid_o,
        output gen_clear_o
    );
endinterface

// File: rtl/mem_bank_load_sequencer.sv
// Job sequencer for one matrix multiply: loads A beats, then B beats, then holds
// compute enable for the systolic pass count and reports done or a rejected job.
module mem_bank_load_sequencer #(
    parameter int unsigned ARRAY_WIDTH      = 4,
    parameter int unsigned BUS_WIDTH_BYTES  = 32,
    parameter int unsigned DATA_WIDTH_BYTES = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start_i,
    input  logic [15:0]                     m,
    input  logic [15:0]                     n,
    input  logic [15:0]                     p,
    mem_bank_load_sequencer_if.slave        bus_if,
    output logic                            compute_en_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int unsigned Epb = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StCompute,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] m_q, m_d;
    logic [15:0] n_q, n_d;
    logic [15:0] p_q, p_d;

    logic gen_start_q, gen_start_d;
    logic bank_a_valid_q, bank_a_valid_d;
    logic bank_b_valid_q, bank_b_valid_d;
    logic gen_clear_q, gen_clear_d;
    logic compute_en_q, compute_en_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    // Job geometry, derived from the latched dimensions.
    logic [31:0] mn, np;
    logic [32:0] mn_up, np_up;
    logic [31:0] beats_a, beats_b;
    logic [15:0] tiles_m, tiles_p;
    logic [31:0] pass_len, compute_cycles;

    assign mn       = {16'd0, m_q} * {16'd0, n_q};
    assign np       = {16'd0, n_q} * {16'd0, p_q};
    assign mn_up    = {1'b0, mn} + 33'(Epb - 1);
    assign np_up    = {1'b0, np} + 33'(Epb - 1);
    assign beats_a  = 32'(mn_up / 33'(Epb));
    assign beats_b  = 32'(np_up / 33'(Epb));
    assign tiles_m  = 16'((17'(m_q) + 17'(ARRAY_WIDTH - 1)) / 17'(ARRAY_WIDTH));
    assign tiles_p  = 16'((17'(p_q) + 17'(ARRAY_WIDTH - 1)) / 17'(ARRAY_WIDTH));
    assign pass_len = {16'd0, n_q} + 32'(2 * ARRAY_WIDTH - 2);
    assign compute_cycles = {16'd0, tiles_m} * {16'd0, tiles_p} * pass_len;

    logic        loading, beat, dims_ok, load_last, compute_last;
    logic [31:0] beats_cur;

    assign loading      = (state_q == StLoadA) || (state_q == StLoadB);
    assign beat         = loading && bus_if.bus_valid_i;
    assign dims_ok      = (m != 16'd0) && (n != 16'd0) && (p != 16'd0);
    assign beats_cur    = (state_q == StLoadB) ? beats_b : beats_a;
    assign load_last    = (cnt_q == beats_cur - 32'd1);
    assign compute_last = (cnt_q == compute_cycles - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            m_q            <= '0;
            n_q            <= '0;
            p_q            <= '0;
            gen_start_q    <= 1'b0;
            bank_a_valid_q <= 1'b0;
            bank_b_valid_q <= 1'b0;
            gen_clear_q    <= 1'b0;
            compute_en_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            m_q            <= m_d;
            n_q            <= n_d;
            p_q            <= p_d;
            gen_start_q    <= gen_start_d;
            bank_a_valid_q <= bank_a_valid_d;
            bank_b_valid_q <= bank_b_valid_d;
            gen_clear_q    <= gen_clear_d;
            compute_en_q   <= compute_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        n_d     = n_q;
        p_d     = p_q;
        unique case (state_q)
            StIdle: begin
                if (start_i && dims_ok) begin
                    m_d     = m;
                    n_d     = n;
                    p_d     = p;
                    cnt_d   = '0;
                    state_d = StLoadA;
                end
            end
            StLoadA, StLoadB: begin
                if (beat) begin
                    if (load_last) begin
                        cnt_d   = '0;
                        state_d = (state_q == StLoadA) ? StLoadB : StCompute;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            StCompute: begin
                if (compute_last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs are decoded from the transition being taken this cycle.
    always_comb begin
        gen_start_d    = (state_q == StIdle) && start_i && dims_ok;
        error_d        = (state_q == StIdle) && start_i && !dims_ok;
        bank_a_valid_d = (state_q == StLoadA) && beat;
        bank_b_valid_d = (state_q == StLoadB) && beat;
        gen_clear_d    = beat && load_last;
        compute_en_d   = (state_d == StCompute);
        busy_d         = (state_d != StIdle);
        done_d         = (state_d == StDone);
    end

    assign bus_if.bus_ready_o    = loading;
    assign bus_if.gen_start_o    = gen_start_q;
    assign bus_if.bank_a_valid_o = bank_a_valid_q;
    assign bus_if.bank_b_valid_o = bank_b_valid_q;
    assign bus_if.gen_clear_o    = gen_clear_q;
    assign compute_en_o          = compute_en_q;
    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign error_o               = error_q;

endmodule

// File: tb/tb_mem_bank_load_sequencer.sv
// Directed bench for the job sequencer: each started job pushes its expected pulse counts,
// which are popped and compared when done_o or error_o appears.
module tb_mem_bank_load_sequencer;

    localparam int unsigned AW  = 4;
    localparam int unsigned EPB = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] m = '0, n = '0, p = '0;
    logic        compute_en_o, busy_o, done_o, error_o;

    mem_bank_load_sequencer_if bus_if ();

    mem_bank_load_sequencer #(
        .ARRAY_WIDTH     (4),
        .BUS_WIDTH_BYTES (32),
        .DATA_WIDTH_BYTES(1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .m           (m),
        .n           (n),
        .p           (p),
        .bus_if      (bus_if),
        .compute_en_o(compute_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    logic [8:0] outs;
    assign outs = {bus_if.bus_ready_o, bus_if.gen_start_o, bus_if.bank_a_valid_o,
                   bus_if.bank_b_valid_o, bus_if.gen_clear_o, compute_en_o, busy_o,
                   done_o, error_o};

    // Pulse/cycle counters, sampled on the falling edge.
    int unsigned n_a = 0, n_b = 0, n_clr = 0, n_ce = 0, n_gs = 0, n_done = 0, n_err = 0;
    always @(negedge clk) begin
        if (bus_if.bank_a_valid_o === 1'b1) n_a    <= n_a + 1;
        if (bus_if.bank_b_valid_o === 1'b1) n_b    <= n_b + 1;
        if (bus_if.gen_clear_o === 1'b1)    n_clr  <= n_clr + 1;
        if (compute_en_o === 1'b1)          n_ce   <= n_ce + 1;
        if (bus_if.gen_start_o === 1'b1)    n_gs   <= n_gs + 1;
        if (done_o === 1'b1)                n_done <= n_done + 1;
        if (error_o === 1'b1)               n_err  <= n_err + 1;
    end

    int unsigned b_a, b_b, b_clr, b_ce, b_gs, b_done, b_err;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned cc;
        bit          err;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input int unsigned mm, nn, pp);
        exp_t e;
        e.a   = (mm * nn + EPB - 1) / EPB;
        e.b   = (nn * pp + EPB - 1) / EPB;
        e.cc  = ((mm + AW - 1) / AW) * ((pp + AW - 1) / AW) * (nn + 2 * AW - 2);
        e.err = (mm == 0) || (nn == 0) || (pp == 0);
        return e;
    endfunction

    task automatic snap();
        b_a = n_a; b_b = n_b; b_clr = n_clr; b_ce = n_ce;
        b_gs = n_gs; b_done = n_done; b_err = n_err;
    endtask

    task automatic launch_job(input int unsigned mm, nn, pp);
        exp_t e;
        e = make_exp(mm, nn, pp);
        sb.push_back(e);
        snap();
        m = 16'(mm); n = 16'(nn); p = 16'(pp);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (e.err) begin
            chk("err_pulse", error_o, 1);
            chk("err_busy", busy_o, 0);
            chk("err_no_gen_start", bus_if.gen_start_o, 0);
            repeat (2) @(posedge clk);
            #1;
            chk("err_busy_after", busy_o, 0);
            e = sb.pop_front();
            chk("err_count", n_err - b_err, 1);
            chk("err_gen_start_count", n_gs - b_gs, 0);
        end else begin
            chk("gen_start_t1", bus_if.gen_start_o, 1);
            chk("bus_ready_t1", bus_if.bus_ready_o, 1);
            chk("busy_t1", busy_o, 1);
        end
    endtask

    // Runs the loaded/computing job until done_o; returns in the middle of the DONE cycle.
    task automatic finish_job(input bit gaps, input bit poke);
        exp_t e;
        bit   got;
        int   pokes;
        got   = 1'b0;
        pokes = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            bus_if.bus_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (poke && compute_en_o && pokes < 3) begin
                start_i = 1'b1;
                pokes++;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            got = (done_o === 1'b1);
        end
        bus_if.bus_valid_i = 1'b0;
        start_i = 1'b0;
        chk("done_seen", got, 1);
        @(negedge clk); #1;
        e = sb.pop_front();
        chk("a_pulses", n_a - b_a, e.a);
        chk("b_pulses", n_b - b_b, e.b);
        chk("clear_pulses", n_clr - b_clr, 2);
        chk("compute_cycles", n_ce - b_ce, e.cc);
        chk("gen_start_pulses", n_gs - b_gs, 1);
        chk("done_pulses", n_done - b_done, 1);
        chk("error_pulses", n_err - b_err, 0);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_done_low", done_o, 0);
    endtask

    initial begin
        exp_t e;
        bit   seen;

        // Reset held while start and bus_valid are asserted.
        bus_if.bus_valid_i = 1'b1;
        start_i = 1'b1;
        m = 16'd4; n = 16'd4; p = 16'd4;
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_outs", outs, 0);
        end
        e = make_exp(4, 4, 4);
        sb.push_back(e);
        snap();
        reset_n = 1'b1;
        #1;
        chk("reset_release_outs", outs, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("first_gen_start", bus_if.gen_start_o, 1);
        chk("first_bus_ready", bus_if.bus_ready_o, 1);
        finish_job(1'b0, 1'b0);
        idle_check();

        // Gapped bus and start poked during COMPUTE.
        launch_job(8, 16, 8);
        finish_job(1'b1, 1'b1);
        idle_check();

        // Non-divisible shape, then a back-to-back start held across DONE.
        launch_job(3, 5, 7);
        finish_job(1'b0, 1'b0);
        e = make_exp(5, 9, 2);
        sb.push_back(e);
        snap();
        m = 16'd5; n = 16'd9; p = 16'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        chk("chain_idle_busy", busy_o, 0);
        chk("chain_no_early_start", bus_if.gen_start_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("chain_gen_start", bus_if.gen_start_o, 1);
        finish_job(1'b1, 1'b0);
        idle_check();

        // Zero-dimension rejects.
        launch_job(4, 0, 4);
        launch_job(0, 3, 3);

        // Abort in LOAD_B.
        launch_job(8, 16, 8);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            bus_if.bus_valid_i = 1'b1;
            @(posedge clk); #1;
            seen = (bus_if.bank_b_valid_o === 1'b1);
        end
        chk("abort_reached_load_b", seen, 1);
        snap();
        reset_n = 1'b0;
        #1;
        chk("abort_outs_zero", outs, 0);
        e = sb.pop_front();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_if.bus_valid_i = 1'b0;
        chk("abort_no_done", n_done - b_done, 0);
        chk("abort_busy", busy_o, 0);

        // Next job after abort loads A and B from zero.
        launch_job(8, 16, 8);
        finish_job(1'b1, 1'b0);
        idle_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
